debouncer_multi: RTL and testbench

//   Parametrised multi-channel debouncer for buttons and switches. Each

---
 rtl/debouncer_multi.sv | 134 +++++++++++++
 tb/tb_debouncer_multi.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debouncer_multi.sv
// Multi-channel debouncer: synchroniser, stability filter, edge pulses per channel.
// Optional long-press detect enabled by defining DEBOUNCER_MULTI_HOLD_EN.
module debouncer_multi #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int HOLD_CYCLES   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] hold
);

  localparam int            CW     = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(STABLE_CYCLES - 1);

  if (WIDTH < 1 || SYNC_STAGES < 2 || STABLE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_params
    $error("debouncer_multi: parameter out of range");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] update;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    level_d = level_q;
    update  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == C_LAST) begin
          cnt_d[i]   = '0;
          level_d[i] = s[i];
          update[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    rise_d = update & s;
    fall_d = update & ~s;
  end

  // NOTE: the counter array is a bank of flops, not a RAM, so it is reset like any register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef DEBOUNCER_MULTI_HOLD_EN
  localparam int            HW     = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);

  logic [HW-1:0]    hcnt_q [WIDTH];
  logic [HW-1:0]    hcnt_d [WIDTH];
  logic [WIDTH-1:0] fired_q, fired_d;
  logic [WIDTH-1:0] hold_q, hold_d;

  // The fired flag parks the counter so a press yields exactly one pulse.
  always_comb begin
    fired_d = fired_q;
    hold_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hcnt_d[i] = hcnt_q[i];
      if (!level_q[i] || update[i]) begin
        hcnt_d[i]  = '0;
        fired_d[i] = 1'b0;
      end else if (tick && !fired_q[i]) begin
        if (hcnt_q[i] == H_LAST) begin
          hold_d[i]  = 1'b1;
          fired_d[i] = 1'b1;
        end else begin
          hcnt_d[i] = hcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fired_q <= '0;
      hold_q  <= '0;
      for (int i = 0; i < WIDTH; i++) hcnt_q[i] <= '0;
    end else begin
      fired_q <= fired_d;
      hold_q  <= hold_d;
      for (int i = 0; i < WIDTH; i++) hcnt_q[i] <= hcnt_d[i];
    end
  end

  assign hold = hold_q;
`else
  assign hold = '0;
`endif

endmodule

// File: tb/tb_debouncer_multi.sv
// Self-checking bench for debouncer_multi (WIDTH=4, SYNC_STAGES=2, STABLE_CYCLES=4, HOLD_CYCLES=10).
// Expected pulses are queued when stimulus is driven and matched as the DUT emits them.
module tb_debouncer_multi;

  localparam int W = 4;

  typedef struct packed {
    logic [23:0] cyc;
    logic [3:0]  ch;
    logic [3:0]  kind;
  } ev_t;

  localparam int K_RISE = 1;
  localparam int K_FALL = 2;
  localparam int K_HOLD = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic [W-1:0] din;
  logic [W-1:0] level, rise, fall, hold;

  int  cyc      = 0;
  int  n_checks = 0;
  int  n_fail   = 0;
  ev_t exp_q[$];

  debouncer_multi #(
    .WIDTH(4), .SYNC_STAGES(2), .STABLE_CYCLES(4), .HOLD_CYCLES(10)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .in(din),
    .level(level), .rise(rise), .fall(fall), .hold(hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_pulse(int kind, int ch, int c);
    ev_t e;
    e.cyc  = 24'(c);
    e.ch   = 4'(ch);
    e.kind = 4'(kind);
    exp_q.push_back(e);
  endfunction

  // Scoreboard: every observed pulse is matched against the oldest expected one.
  always @(negedge clk) begin : monitor
    logic p;
    ev_t  obs, want;
    if (rst === 1'b0) begin
      for (int ch = 0; ch < W; ch++) begin
        for (int k = K_RISE; k <= K_HOLD; k++) begin
          p = (k == K_RISE) ? rise[ch] : (k == K_FALL) ? fall[ch] : hold[ch];
          if (p === 1'b1) begin
            obs.cyc  = 24'(cyc);
            obs.ch   = 4'(ch);
            obs.kind = 4'(k);
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL pulse_unexpected: got kind=%0d ch=%0d cyc=%0d, required no pulse",
                       k, ch, cyc);
            end else begin
              want = exp_q.pop_front();
              if (obs !== want) begin
                n_fail++;
                $display("FAIL pulse_match: got kind=%0d ch=%0d cyc=%0d, required kind=%0d ch=%0d cyc=%0d",
                         obs.kind, obs.ch, obs.cyc, want.kind, want.ch, want.cyc);
              end
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst  = 1'b1;
    din  = 4'hF;
    tick = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({level, rise, fall, hold} !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_active: got %h, required 0000", {level, rise, fall, hold});
      end
    end
    din = '0;
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      n_checks++;
      if ({level, rise, fall, hold} !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_release: got %h, required 0000", {level, rise, fall, hold});
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_pending: got %0d unmatched, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_debounce();
    int t0, t1;
    @(negedge clk);
    din[0] = 1'b1;
    t0 = cyc;
    expect_pulse(K_RISE, 0, t0 + 6);
    repeat (5) @(negedge clk);
    n_checks++;
    if (level[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL debounce_early: got level0=%b, required 0", level[0]);
    end
    @(negedge clk);
    n_checks++;
    if ({level[0], rise[0]} !== 2'b11) begin
      n_fail++;
      $display("FAIL debounce_rise: got level0,rise0=%b, required 11", {level[0], rise[0]});
    end
    @(negedge clk);
    n_checks++;
    if ({level[0], rise[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL debounce_rise_end: got level0,rise0=%b, required 10", {level[0], rise[0]});
    end
    din[0] = 1'b0;
    t1 = cyc;
    expect_pulse(K_FALL, 0, t1 + 6);
    repeat (6) @(negedge clk);
    n_checks++;
    if ({level[0], fall[0]} !== 2'b01) begin
      n_fail++;
      $display("FAIL debounce_fall: got level0,fall0=%b, required 01", {level[0], fall[0]});
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL debounce_pending: got %0d unmatched, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_glitch();
    int t;
    @(negedge clk);
    din[1] = 1'b1;
    repeat (3) @(negedge clk);
    din[1] = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (level[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_short: got level1=%b, required 0", level[1]);
    end
    din[1] = 1'b1;
    t = cyc;
    expect_pulse(K_RISE, 1, t + 6);
    repeat (7) @(negedge clk);
    din[1] = 1'b0;
    @(negedge clk);
    din[1] = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (level[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_dip: got level1=%b, required 1", level[1]);
    end
`ifdef DEBOUNCER_MULTI_HOLD_EN
    expect_pulse(K_HOLD, 1, t + 16);
`endif
    din[1] = 1'b0;
    expect_pulse(K_FALL, 1, cyc + 6);
    repeat (8) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL glitch_pending: got %0d unmatched, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_tick_gating();
    int t0;
    @(negedge clk);
    din[2] = 1'b1;
    t0 = cyc;
    expect_pulse(K_RISE, 2, t0 + 15);
    for (int k = 0; k < 18; k++) begin
      tick = (k % 4 == 2);
      if (k == 11 || k == 14) begin
        n_checks++;
        if (level[2] !== 1'b0) begin
          n_fail++;
          $display("FAIL tick_early: got level2=%b at step %0d, required 0", level[2], k);
        end
      end
      if (k == 15) begin
        n_checks++;
        if ({level[2], rise[2]} !== 2'b11) begin
          n_fail++;
          $display("FAIL tick_rise: got level2,rise2=%b, required 11", {level[2], rise[2]});
        end
      end
      @(negedge clk);
    end
    tick   = 1'b1;
    din[2] = 1'b0;
    expect_pulse(K_FALL, 2, cyc + 6);
    repeat (8) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL tick_pending: got %0d unmatched, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midcount();
    int tr;
    @(negedge clk);
    din[0] = 1'b1;
    expect_pulse(K_RISE, 0, cyc + 6);
    repeat (6) @(negedge clk);
    din[3:2] = 2'b11;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({level, rise, fall, hold} !== 16'h0) begin
      n_fail++;
      $display("FAIL midrst_clear: got %h, required 0000", {level, rise, fall, hold});
    end
    @(negedge clk);
    rst = 1'b0;
    tr  = cyc;
    expect_pulse(K_RISE, 0, tr + 6);
    expect_pulse(K_RISE, 2, tr + 6);
    expect_pulse(K_RISE, 3, tr + 6);
    repeat (5) @(negedge clk);
    n_checks++;
    if (level !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_early: got level=%b, required 0000", level);
    end
    @(negedge clk);
    n_checks++;
    if ({level, rise} !== 8'b1101_1101) begin
      n_fail++;
      $display("FAIL midrst_rise: got level,rise=%b, required 11011101", {level, rise});
    end
    @(negedge clk);
    din = '0;
    expect_pulse(K_FALL, 0, cyc + 6);
    expect_pulse(K_FALL, 2, cyc + 6);
    expect_pulse(K_FALL, 3, cyc + 6);
    repeat (8) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || level !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_pending: got %0d unmatched level=%b, required 0 and 0000",
               exp_q.size(), level);
    end
    exp_q.delete();
  endtask

  task automatic test_hold();
    int t0;
    logic hold_exp;
`ifdef DEBOUNCER_MULTI_HOLD_EN
    hold_exp = 1'b1;
`else
    hold_exp = 1'b0;
`endif
    @(negedge clk);
    din[0] = 1'b1;
    t0 = cyc;
    expect_pulse(K_RISE, 0, t0 + 6);
`ifdef DEBOUNCER_MULTI_HOLD_EN
    expect_pulse(K_HOLD, 0, t0 + 16);
`endif
    repeat (16) @(negedge clk);
    n_checks++;
    if (hold[0] !== hold_exp) begin
      n_fail++;
      $display("FAIL hold_pulse: got hold0=%b, required %b", hold[0], hold_exp);
    end
    repeat (24) @(negedge clk);
    din[0] = 1'b0;
    expect_pulse(K_FALL, 0, cyc + 6);
    repeat (12) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || level !== 4'b0000) begin
      n_fail++;
      $display("FAIL hold_pending: got %0d unmatched level=%b, required 0 and 0000",
               exp_q.size(), level);
    end
    exp_q.delete();
  endtask

  initial begin
    rst  = 1'b1;
    tick = 1'b1;
    din  = '0;
    test_reset();
    test_debounce();
    test_glitch();
    test_tick_gating();
    test_reset_midcount();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
